btb_assoc: RTL and testbench

- Parametrised N-way set-associative branch target buffer with a 2-bit saturating predictor per entry and true-LRU replacement.
- Lookup port is consumed by IF (predicted next PC); update port is driven by EX on branch resolution.
- Adds three features: configurable sets/ways, an allocate-on-taken policy, and a multi-cycle flush sequencer (e.g. for fence.i / context switch).

---
 rtl/btb_assoc.sv | 188 ++++++++++++++++++
 tb/tb_btb_assoc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/btb_assoc.sv
// N-way set-associative branch target buffer.
// Each entry holds a 2-bit saturating predictor. Replacement is true LRU.
// A multi-cycle flush sequencer invalidates one set per cycle.
module btb_assoc #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_pc,
  output logic              rd_hit,
  output logic              rd_taken,
  output logic [ADDR_W-1:0] rd_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush_req,
  output logic              flush_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;
  localparam int unsigned AGE_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef logic [NUM_WAYS-1:0][AGE_W-1:0] age_t;
  typedef enum logic {StIdle, StFlush} fsm_e;

  logic [NUM_WAYS-1:0]             valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0]             valid_d  [NUM_SETS];
  logic [NUM_WAYS-1:0][TAG_W-1:0]  tag_q    [NUM_SETS];
  logic [NUM_WAYS-1:0][TAG_W-1:0]  tag_d    [NUM_SETS];
  logic [NUM_WAYS-1:0][ADDR_W-1:0] target_q [NUM_SETS];
  logic [NUM_WAYS-1:0][ADDR_W-1:0] target_d [NUM_SETS];
  logic [NUM_WAYS-1:0][1:0]        state_q  [NUM_SETS];
  logic [NUM_WAYS-1:0][1:0]        state_d  [NUM_SETS];
  age_t                            age_q    [NUM_SETS];
  age_t                            age_d    [NUM_SETS];
  fsm_e                            fsm_q, fsm_d;
  logic [IDX_W-1:0]                cnt_q, cnt_d;

  logic [IDX_W-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;
  logic             rd_hit_raw, upd_hit, vic_found, upd_touch;
  logic [AGE_W-1:0] rd_way, upd_way, vic_way;
  logic             unused_pc_bits;

  assign rd_idx  = rd_pc[IDX_W+1:2];
  assign rd_tag  = rd_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_pc_bits = ^{rd_pc[1:0], upd_pc[1:0]};

  function automatic age_t init_ages();
    age_t a;
    for (int w = 0; w < NUM_WAYS; w++) a[w] = AGE_W'(w);
    return a;
  endfunction

  // Touched way becomes MRU; ways younger than its old age get one step older.
  function automatic age_t touch(age_t ages, logic [AGE_W-1:0] way);
    age_t res;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (AGE_W'(w) == way)        res[w] = '0;
      else if (ages[w] < ages[way]) res[w] = ages[w] + 1'b1;
      else                          res[w] = ages[w];
    end
    return res;
  endfunction

  // Gray-like ordering 00 -> 01 -> 11 -> 10 keeps bit 1 as the prediction.
  function automatic logic [1:0] step(logic [1:0] s, logic taken);
    logic [1:0] n;
    unique case (s)
      2'b00:   n = taken ? 2'b01 : 2'b00;
      2'b01:   n = taken ? 2'b11 : 2'b00;
      2'b11:   n = taken ? 2'b10 : 2'b01;
      default: n = taken ? 2'b10 : 2'b11;
    endcase
    return n;
  endfunction

  // Tag compare for the lookup and update ports, plus victim selection.
  always_comb begin
    rd_hit_raw = 1'b0;
    rd_way     = '0;
    upd_hit    = 1'b0;
    upd_way    = '0;
    vic_found  = 1'b0;
    vic_way    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
        rd_hit_raw = 1'b1;
        rd_way     = AGE_W'(w);
      end
      if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
        upd_hit = 1'b1;
        upd_way = AGE_W'(w);
      end
      if (!vic_found && !valid_q[upd_idx][w]) begin
        vic_found = 1'b1;
        vic_way   = AGE_W'(w);
      end
    end
    if (!vic_found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[upd_idx][w] == AGE_W'(NUM_WAYS - 1)) vic_way = AGE_W'(w);
      end
    end
  end

  // Lookup outputs are forced to zero while the flush sequencer runs.
  always_comb begin
    rd_hit     = rd_hit_raw && (fsm_q == StIdle);
    rd_taken   = rd_hit && state_q[rd_idx][rd_way][1];
    rd_target  = rd_hit ? target_q[rd_idx][rd_way] : '0;
    flush_busy = (fsm_q == StFlush);
  end

  // Next-state for the arrays, the LRU ages and the flush sequencer.
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    target_d  = target_q;
    state_d   = state_q;
    age_d     = age_q;
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    upd_touch = 1'b0;
    if (fsm_q == StIdle) begin
      // A flush request in the same cycle drops the update.
      if (upd_valid && !flush_req) begin
        if (upd_hit) begin
          state_d[upd_idx][upd_way] = step(state_q[upd_idx][upd_way], upd_taken);
          if (upd_taken) target_d[upd_idx][upd_way] = upd_target;
          age_d[upd_idx] = touch(age_q[upd_idx], upd_way);
          upd_touch      = 1'b1;
        end else if (upd_taken) begin
          valid_d[upd_idx][vic_way]  = 1'b1;
          tag_d[upd_idx][vic_way]    = upd_tag;
          target_d[upd_idx][vic_way] = upd_target;
          state_d[upd_idx][vic_way]  = 2'b11;
          age_d[upd_idx]             = touch(age_q[upd_idx], vic_way);
          upd_touch                  = 1'b1;
        end
      end
      // Update touch wins when both ports land in the same set.
      if (rd_en && rd_hit_raw && !(upd_touch && upd_idx == rd_idx)) begin
        age_d[rd_idx] = touch(age_q[rd_idx], rd_way);
      end
      if (flush_req) begin
        fsm_d = StFlush;
        cnt_d = '0;
      end
    end else begin
      valid_d[cnt_q] = '0;
      age_d[cnt_q]   = init_ages();
      cnt_d          = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(NUM_SETS - 1)) fsm_d = StIdle;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s]  <= '0;
        tag_q[s]    <= '0;
        target_q[s] <= '0;
        state_q[s]  <= '0;
        age_q[s]    <= init_ages();
      end
      fsm_q <= StIdle;
      cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      state_q  <= state_d;
      age_q    <= age_d;
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc at default parameters.
// Sets: idx = pc[4:2]; 0x100/0x120/0x140/0x160/0x300 all map to set 0.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst, rd_en, upd_valid, upd_taken, flush_req;
  logic [31:0] rd_pc, upd_pc, upd_target, rd_target;
  logic        rd_hit, rd_taken, flush_busy;
  int          tests = 0;
  int          fails = 0;

  btb_assoc dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_pc      (rd_pc),
    .rd_hit     (rd_hit),
    .rd_taken   (rd_taken),
    .rd_target  (rd_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .flush_req  (flush_req),
    .flush_busy (flush_busy)
  );

  always #5 clk = ~clk;

  // Apply one update for one clock edge; returns at posedge+1.
  task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    @(posedge clk); #1;
    upd_valid = 1'b0;
  endtask

  // Present a lookup address and let combinational outputs settle.
  task automatic look(input logic [31:0] pc);
    rd_pc = pc; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; rd_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_en = 1'b1; look(32'h100);
    tests++;
    if ({rd_hit, rd_taken, rd_target, flush_busy} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset: hit=%0b taken=%0b tgt=%h busy=%0b want 0 0 0 0",
               rd_hit, rd_taken, rd_target, flush_busy);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_predictor();
    do_upd(32'h100, 1'b1, 32'h200);
    look(32'h100); tests++;
    if ({rd_hit, rd_taken, rd_target} !== {1'b1, 1'b1, 32'h200}) begin
      fails++; $display("FAIL alloc_11: %0b %0b %h want 1 1 200", rd_hit, rd_taken, rd_target);
    end
    do_upd(32'h100, 1'b0, 32'h0);
    look(32'h100); tests++;
    if ({rd_hit, rd_taken, rd_target} !== {1'b1, 1'b0, 32'h200}) begin
      fails++; $display("FAIL nt_01: %0b %0b %h want 1 0 200", rd_hit, rd_taken, rd_target);
    end
    do_upd(32'h100, 1'b0, 32'h0);
    look(32'h100); tests++;
    if ({rd_hit, rd_taken} !== 2'b10) begin
      fails++; $display("FAIL nt_00: %0b %0b want 1 0", rd_hit, rd_taken);
    end
    // From 00 one taken reaches only 01 (not-taken prediction).
    do_upd(32'h100, 1'b1, 32'h200);
    look(32'h100); tests++;
    if ({rd_hit, rd_taken} !== 2'b10) begin
      fails++; $display("FAIL t_01: %0b %0b want 1 0", rd_hit, rd_taken);
    end
    do_upd(32'h100, 1'b1, 32'h200);
    look(32'h100); tests++;
    if ({rd_hit, rd_taken, rd_target} !== {1'b1, 1'b1, 32'h200}) begin
      fails++; $display("FAIL t_11: %0b %0b %h want 1 1 200", rd_hit, rd_taken, rd_target);
    end
  endtask

  task automatic test_lru();
    do_upd(32'h120, 1'b1, 32'h220);
    // Read touch of 0x100 makes 0x120 the LRU way.
    rd_en = 1'b1; rd_pc = 32'h100;
    @(posedge clk); #1;
    rd_en = 1'b0;
    do_upd(32'h140, 1'b1, 32'h240);
    look(32'h120); tests++;
    if (rd_hit !== 1'b0) begin
      fails++; $display("FAIL lru_evict: hit=%0b want 0", rd_hit);
    end
    look(32'h100); tests++;
    if ({rd_hit, rd_target} !== {1'b1, 32'h200}) begin
      fails++; $display("FAIL lru_keep: %0b %h want 1 200", rd_hit, rd_target);
    end
    look(32'h140); tests++;
    if ({rd_hit, rd_taken, rd_target} !== {1'b1, 1'b1, 32'h240}) begin
      fails++; $display("FAIL lru_new: %0b %0b %h want 1 1 240", rd_hit, rd_taken, rd_target);
    end
  endtask

  task automatic test_same_cycle();
    upd_valid = 1'b1; upd_pc = 32'h140; upd_taken = 1'b1; upd_target = 32'h440;
    look(32'h140); tests++;
    if (rd_target !== 32'h240) begin
      fails++; $display("FAIL no_bypass: tgt=%h want 240", rd_target);
    end
    @(posedge clk); #1;
    upd_valid = 1'b0;
    look(32'h140); tests++;
    if (rd_target !== 32'h440) begin
      fails++; $display("FAIL upd_target: tgt=%h want 440", rd_target);
    end
  endtask

  task automatic test_no_rd_en_touch();
    // Ages now: 0x140 MRU, 0x100 LRU. A read without rd_en must not touch.
    rd_en = 1'b0; rd_pc = 32'h100;
    @(posedge clk); #1;
    do_upd(32'h160, 1'b1, 32'h260);
    look(32'h100); tests++;
    if (rd_hit !== 1'b0) begin
      fails++; $display("FAIL rd_en_qual: hit=%0b want 0", rd_hit);
    end
    look(32'h160); tests++;
    if ({rd_hit, rd_target} !== {1'b1, 32'h260}) begin
      fails++; $display("FAIL alloc_160: %0b %h want 1 260", rd_hit, rd_target);
    end
  endtask

  task automatic test_no_alloc();
    do_upd(32'h300, 1'b0, 32'h500);
    look(32'h300); tests++;
    if (rd_hit !== 1'b0) begin
      fails++; $display("FAIL nt_miss_alloc: hit=%0b want 0", rd_hit);
    end
    look(32'h140); tests++;
    if (rd_hit !== 1'b1) begin
      fails++; $display("FAIL nt_miss_keep140: hit=%0b want 1", rd_hit);
    end
    look(32'h160); tests++;
    if (rd_hit !== 1'b1) begin
      fails++; $display("FAIL nt_miss_keep160: hit=%0b want 1", rd_hit);
    end
  endtask

  task automatic test_flush();
    int cnt;
    logic [31:0] pcs [5];
    pcs = '{32'h104, 32'h108, 32'h11C, 32'h140, 32'h100};
    do_upd(32'h104, 1'b1, 32'h600);
    do_upd(32'h108, 1'b1, 32'h604);
    do_upd(32'h11C, 1'b1, 32'h608);
    look(32'h11C); tests++;
    if (rd_hit !== 1'b1) begin
      fails++; $display("FAIL fill_11c: hit=%0b want 1", rd_hit);
    end
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    cnt = 0;
    while (flush_busy === 1'b1 && cnt < 20) begin
      cnt++;
      if (cnt == 1) begin
        look(32'h11C); tests++;
        if (rd_hit !== 1'b0) begin
          fails++; $display("FAIL flush_rd_gate: hit=%0b want 0", rd_hit);
        end
      end
      // Sets 0 and 1 are already cleared here, so a dropped update stays gone.
      if (cnt == 3) begin
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h700;
        flush_req = 1'b1;
      end
      @(posedge clk); #1;
      upd_valid = 1'b0; flush_req = 1'b0;
    end
    tests++;
    if (cnt !== 8) begin
      fails++; $display("FAIL flush_len: busy cycles=%0d want 8", cnt);
    end
    for (int i = 0; i < 5; i++) begin
      look(pcs[i]); tests++;
      if (rd_hit !== 1'b0) begin
        fails++; $display("FAIL post_flush_%h: hit=%0b want 0", pcs[i], rd_hit);
      end
    end
  endtask

  task automatic test_reset_in_flush();
    do_upd(32'h11C, 1'b1, 32'h808);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    look(32'h11C); tests++;
    if ({flush_busy, rd_hit} !== 2'b00) begin
      fails++; $display("FAIL rst_abort: busy=%0b hit=%0b want 0 0", flush_busy, rd_hit);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    look(32'h11C); tests++;
    if ({flush_busy, rd_hit} !== 2'b00) begin
      fails++; $display("FAIL rst_after: busy=%0b hit=%0b want 0 0", flush_busy, rd_hit);
    end
    do_upd(32'h11C, 1'b1, 32'h90C);
    look(32'h11C); tests++;
    if ({rd_hit, rd_taken, rd_target} !== {1'b1, 1'b1, 32'h90C}) begin
      fails++; $display("FAIL rst_realloc: %0b %0b %h want 1 1 90c", rd_hit, rd_taken, rd_target);
    end
  endtask

  initial begin
    test_reset();
    test_predictor();
    test_lru();
    test_same_cycle();
    test_no_rd_en_touch();
    test_no_alloc();
    test_flush();
    test_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
